// File: rtl/axis_traffic_gen.sv
// AXI-Stream traffic generator: Bernoulli injection, random destination, timestamp + per-destination sequence payload.
// Optional AXIS_TG_DROP_COUNT_EN adds a dropped_events counter for injection events lost to a full queue.
module axis_traffic_gen #(
  parameter int unsigned SEED          = 2,
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned TID           = 0,
  parameter int unsigned TDATA_WIDTH   = 64,
  parameter int unsigned TDEST_WIDTH   = 2,
  parameter int unsigned TID_WIDTH     = 2,
  parameter int unsigned NUM_ROUTERS   = 4,
  parameter int unsigned BACKLOG_DEPTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [15:0]                               load,
  input  logic [COUNT_WIDTH-1:0]                    num_packets,
  input  logic                                      start,
  input  logic [TDATA_WIDTH/2-1:0]                  ticks,
  output logic                                      done,
  output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0]   sent_packets,
  output logic [COUNT_WIDTH-1:0]                    total_sent_packets,
`ifdef AXIS_TG_DROP_COUNT_EN
  output logic [COUNT_WIDTH-1:0]                    dropped_events,
`endif
  output logic                                      axis_out_tvalid,
  input  logic                                      axis_out_tready,
  output logic [TDATA_WIDTH-1:0]                    axis_out_tdata,
  output logic                                      axis_out_tlast,
  output logic [TID_WIDTH-1:0]                      axis_out_tid,
  output logic [TDEST_WIDTH-1:0]                    axis_out_tdest
);
  localparam int unsigned TICK_W = TDATA_WIDTH / 2;
  localparam int unsigned PTR_W  = $clog2(BACKLOG_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [15:0] SEED_A_RAW = SEED[15:0];
  localparam logic [15:0] SEED_B_RAW = SEED[15:0] ^ 16'hACE1;
  localparam logic [15:0] SEED_A = (SEED_A_RAW == 16'd0) ? 16'd1 : SEED_A_RAW;
  localparam logic [15:0] SEED_B = (SEED_B_RAW == 16'd0) ? 16'd1 : SEED_B_RAW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
  endfunction

  logic [1:0]                             r_state, w_state_next;
  logic                                   r_done;
  logic [15:0]                            r_lfsr_a, r_lfsr_b;
  logic [COUNT_WIDTH-1:0]                 r_gen_count, r_total;
  logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] r_sent;
  logic [TICK_W-1:0]                      r_q_tick [BACKLOG_DEPTH];
  logic [TDEST_WIDTH-1:0]                 r_q_dest [BACKLOG_DEPTH];
  logic [PTR_W-1:0]                       r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]                       r_cnt;
  logic                                   r_tvalid, r_tlast;
  logic [TDATA_WIDTH-1:0]                 r_tdata;
  logic [TDEST_WIDTH-1:0]                 r_tdest;

  logic                   w_run, w_start_run, w_event, w_out_free, w_hs;
  logic                   w_q_empty, w_q_full, w_pop, w_push_ok, w_bypass, w_q_wr;
  logic [TDEST_WIDTH-1:0] w_dest, w_ld_dest;
  logic [TICK_W-1:0]      w_ld_tick;
  logic [COUNT_WIDTH-1:0] w_ld_cnt;

  assign w_run       = (r_state == S_RUN);
  assign w_start_run = (r_state == S_IDLE) && start;
  assign w_event     = w_run && (r_lfsr_a < load) && (r_gen_count < num_packets);
  assign w_hs        = r_tvalid && axis_out_tready;
  assign w_out_free  = !r_tvalid || axis_out_tready;
  assign w_q_empty   = (r_cnt == '0);
  assign w_q_full    = (r_cnt == CNT_W'(BACKLOG_DEPTH));
  assign w_pop       = w_out_free && !w_q_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push_ok   = w_event && (!w_q_full || w_pop);
  assign w_bypass    = w_push_ok && w_out_free && w_q_empty;
  assign w_q_wr      = w_push_ok && !w_bypass;
  assign w_dest      = TDEST_WIDTH'(32'(r_lfsr_b) % NUM_ROUTERS);

  // Beat to load; its sequence number accounts for a handshake to the same dest this cycle.
  always_comb begin
    w_ld_dest = w_pop ? r_q_dest[r_rd_ptr] : w_dest;
    w_ld_tick = w_pop ? r_q_tick[r_rd_ptr] : ticks;
    w_ld_cnt  = r_sent[w_ld_dest];
    if (w_hs && (r_tdest == w_ld_dest)) w_ld_cnt = w_ld_cnt + COUNT_WIDTH'(1);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN:  if ((r_gen_count == num_packets) && w_q_empty && !r_tvalid) w_state_next = S_DONE;
      S_DONE: if (!start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_lfsr_a <= SEED_A;
      r_lfsr_b <= SEED_B;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == S_DONE);
      if (w_run) begin
        r_lfsr_a <= lfsr_next(r_lfsr_a);
        r_lfsr_b <= lfsr_next(r_lfsr_b);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gen_count <= '0;
      r_total     <= '0;
      r_sent      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
    end else if (w_start_run) begin
      r_gen_count <= '0;
      r_total     <= '0;
      r_sent      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_push_ok) r_gen_count <= r_gen_count + COUNT_WIDTH'(1);
      if (w_hs) begin
        r_sent[r_tdest] <= r_sent[r_tdest] + COUNT_WIDTH'(1);
        r_total         <= r_total + COUNT_WIDTH'(1);
      end
      if (w_q_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_q_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_q_wr) begin
      r_q_tick[r_wr_ptr] <= ticks;
      r_q_dest[r_wr_ptr] <= w_dest;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tdest  <= '0;
      r_tlast  <= 1'b0;
    end else if (w_out_free) begin
      r_tvalid <= w_pop || w_bypass;
      if (w_pop || w_bypass) begin
        r_tdata <= {w_ld_tick, TICK_W'(w_ld_cnt)};
        r_tdest <= w_ld_dest;
        r_tlast <= 1'b1;
      end
    end
  end

`ifdef AXIS_TG_DROP_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_dropped;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_dropped <= '0;
    else if (w_start_run)            r_dropped <= '0;
    else if (w_event && !w_push_ok)  r_dropped <= r_dropped + COUNT_WIDTH'(1);
  end
  assign dropped_events = r_dropped;
`endif

  assign done               = r_done;
  assign sent_packets       = r_sent;
  assign total_sent_packets = r_total;
  assign axis_out_tvalid    = r_tvalid;
  assign axis_out_tdata     = r_tdata;
  assign axis_out_tdest     = r_tdest;
  assign axis_out_tlast     = r_tlast;
  assign axis_out_tid       = TID_WIDTH'(TID);
endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed self-checking bench for axis_traffic_gen (default parameters).
module tb_axis_traffic_gen;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       load = '0;
  logic [31:0]       num_packets = '0;
  logic              start = 1'b0;
  logic [31:0]       ticks = '0;
  logic              done;
  logic [3:0][31:0]  sent_packets;
  logic [31:0]       total_sent;
  logic              tvalid, tready = 1'b0, tlast;
  logic [63:0]       tdata;
  logic [1:0]        tid, tdest;
`ifdef AXIS_TG_DROP_COUNT_EN
  logic [31:0]       dropped_events;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  axis_traffic_gen dut (
    .clk(clk), .rst(rst), .load(load), .num_packets(num_packets), .start(start), .ticks(ticks),
    .done(done), .sent_packets(sent_packets), .total_sent_packets(total_sent),
`ifdef AXIS_TG_DROP_COUNT_EN
    .dropped_events(dropped_events),
`endif
    .axis_out_tvalid(tvalid), .axis_out_tready(tready), .axis_out_tdata(tdata),
    .axis_out_tlast(tlast), .axis_out_tid(tid), .axis_out_tdest(tdest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ticks <= ticks + 32'd1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
  endfunction

  function automatic logic [31:0] sent_sum();
    return sent_packets[0] + sent_packets[1] + sent_packets[2] + sent_packets[3];
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; tready = 1'b0; load = '0; num_packets = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (tdata !== 64'd0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    n_checks++; if (tdest !== 2'd0 || tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tdest_tlast: got %0d/%b want 0/0", tdest, tlast); end
    n_checks++; if (tid !== 2'd0) begin n_fail++; $display("FAIL reset_tid: got %0d want 0", tid); end
    n_checks++; if (total_sent !== 32'd0 || sent_sum() !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", total_sent, sent_sum()); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full load, always ready: beats in LFSR order, seq from 0 per dest, tick from injection cycle.
  task automatic test_full_load;
    logic [1:0]  exp_dest [16];
    logic [15:0] a, b;
    int cnt [4];
    int k, n, cyc;
    a = 16'h0002; b = 16'h0002 ^ 16'hACE1; k = 0;
    while (k < 16) begin
      if (a < 16'hFFFF) begin exp_dest[k] = 2'(b % 16'd4); k++; end
      a = lfsr_step(a); b = lfsr_step(b);
    end
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    load = 16'hFFFF; num_packets = 32'd16; tready = 1'b1; start = 1'b1;
    n = 0; cyc = 0;
    while (n < 16 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (tvalid === 1'b1) begin
        n_checks++; if (tdest !== exp_dest[n]) begin n_fail++; $display("FAIL full_dest[%0d]: got %0d want %0d", n, tdest, exp_dest[n]); end
        n_checks++; if (tdata[31:0] !== 32'(cnt[tdest])) begin n_fail++; $display("FAIL full_seq[%0d]: got %0d want %0d", n, tdata[31:0], cnt[tdest]); end
        n_checks++; if (tdata[63:32] !== ticks - 32'd1) begin n_fail++; $display("FAIL full_tick[%0d]: got %0d want %0d", n, tdata[63:32], ticks - 32'd1); end
        n_checks++; if (tlast !== 1'b1) begin n_fail++; $display("FAIL full_tlast[%0d]: got %b want 1", n, tlast); end
        cnt[tdest]++; n++;
      end
    end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL full_beats: got %0d want 16", n); end
    @(negedge clk);
    n_checks++; if (tvalid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL full_after_last: got tvalid=%b done=%b want 0/0", tvalid, done); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", done); end
    n_checks++; if (total_sent !== 32'd16 || sent_sum() !== 32'd16) begin n_fail++; $display("FAIL full_totals: got %0d/%0d want 16/16", total_sent, sent_sum()); end
    for (int d = 0; d < 4; d++) begin
      n_checks++; if (sent_packets[d] !== 32'(cnt[d])) begin n_fail++; $display("FAIL full_sent[%0d]: got %0d want %0d", d, sent_packets[d], cnt[d]); end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_idle_done: got %b want 0", done); end
  endtask

  task automatic test_zero_load;
    int bad_v, bad_d;
    bad_v = 0; bad_d = 0;
    load = 16'd0; num_packets = 32'd16; tready = 1'b1; start = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (tvalid !== 1'b0) bad_v++;
      if (done !== 1'b0) bad_d++;
    end
    n_checks++; if (bad_v != 0) begin n_fail++; $display("FAIL zero_load_tvalid: got %0d valid cycles want 0", bad_v); end
    n_checks++; if (bad_d != 0) begin n_fail++; $display("FAIL zero_load_done: got %0d done cycles want 0", bad_d); end
  endtask

  task automatic test_zero_packets;
    int cyc;
    do_reset;
    load = 16'hFFFF; num_packets = 32'd0; tready = 1'b1; start = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3) begin @(negedge clk); cyc++; end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_pkts_done: got %b want 1 within 3 cycles", done); end
    n_checks++; if (tvalid !== 1'b0 || total_sent !== 32'd0) begin n_fail++; $display("FAIL zero_pkts_idle_bus: got tvalid=%b total=%0d want 0/0", tvalid, total_sent); end
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pkts_back_idle: got %b want 0", done); end
  endtask

  // Stall with full load: first beat frozen, 1 + BACKLOG_DEPTH packets held, then drained.
  task automatic test_backpressure;
    logic [63:0] d0;
    logic [1:0]  t0;
    int cnt [4];
    int cyc, unstable, beats;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    do_reset;
    load = 16'hFFFF; num_packets = 32'd20; tready = 1'b0; start = 1'b1;
    cyc = 0;
    while (tvalid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    d0 = tdata; t0 = tdest;
    n_checks++; if (tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", tvalid); end
    n_checks++; if (t0 !== 2'd3 || d0[31:0] !== 32'd0) begin n_fail++; $display("FAIL bp_first_beat: got dest=%0d seq=%0d want 3/0", t0, d0[31:0]); end
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (tvalid !== 1'b1 || tdata !== d0 || tdest !== t0) unstable++;
    end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); end
`ifdef AXIS_TG_DROP_COUNT_EN
    n_checks++; if (dropped_events == 32'd0) begin n_fail++; $display("FAIL bp_dropped: got %0d want nonzero", dropped_events); end
`endif
    load = 16'd0; tready = 1'b1; beats = 0;
    repeat (30) begin
      if (tvalid === 1'b1) begin
        if (tdata[31:0] !== 32'(cnt[tdest])) begin n_fail++; $display("FAIL bp_seq: got %0d want %0d", tdata[31:0], cnt[tdest]); end
        cnt[tdest]++; beats++;
      end
      @(negedge clk);
    end
    n_checks++; if (beats != 9) begin n_fail++; $display("FAIL bp_buffered: got %0d want 9", beats); end
    load = 16'hFFFF; cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (tvalid === 1'b1) cnt[tdest]++;
    end
    n_checks++; if (done !== 1'b1 || total_sent !== 32'd20) begin n_fail++; $display("FAIL bp_complete: got done=%b total=%0d want 1/20", done, total_sent); end
    n_checks++; if (sent_sum() !== 32'd20) begin n_fail++; $display("FAIL bp_sum: got %0d want 20", sent_sum()); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Async reset mid-run kills the beat at once; the rerun repeats the same beats.
  task automatic test_async_reset;
    logic [1:0]  rec_dest [6];
    logic [31:0] rec_seq [6];
    int n, cyc, bad;
    do_reset;
    load = 16'hFFFF; num_packets = 32'd16; tready = 1'b1; start = 1'b1;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (tvalid === 1'b1) begin rec_dest[n] = tdest; rec_seq[n] = tdata[31:0]; n++; end
    end
    @(negedge clk);
    n_checks++; if (tvalid !== 1'b1 || total_sent == 32'd0) begin n_fail++; $display("FAIL ar_pre: got tvalid=%b total=%0d want 1/nonzero", tvalid, total_sent); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL ar_tvalid: got %b want 0", tvalid); end
    n_checks++; if (total_sent !== 32'd0 || sent_sum() !== 32'd0) begin n_fail++; $display("FAIL ar_counters: got %0d/%0d want 0/0", total_sent, sent_sum()); end
    @(negedge clk);
    rst = 1'b0;
    n = 0; cyc = 0; bad = 0;
    while (n < 6 && cyc < 50) begin
      @(negedge clk); cyc++;
      if (tvalid === 1'b1) begin
        if (tdest !== rec_dest[n] || tdata[31:0] !== rec_seq[n]) bad++;
        n++;
      end
    end
    n_checks++; if (bad != 0 || n != 6) begin n_fail++; $display("FAIL ar_rerun: got %0d mismatched of %0d beats want 0 of 6", bad, n); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    n_checks++; if (total_sent !== 32'd16) begin n_fail++; $display("FAIL ar_total: got %0d want 16", total_sent); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random;
    logic [63:0] p_data;
    logic [1:0]  p_dest;
    logic        p_stall;
    int cnt [4];
    int n, cyc, bad_dest, bad_seq, bad_hold;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    do_reset;
    load = 16'd32767; num_packets = 32'd4096; start = 1'b1;
    n = 0; cyc = 0; bad_dest = 0; bad_seq = 0; bad_hold = 0;
    p_stall = 1'b0; p_data = '0; p_dest = '0;
    while (done !== 1'b1 && cyc < 40000) begin
      @(negedge clk); cyc++;
      if (p_stall && (tvalid !== 1'b1 || tdata !== p_data || tdest !== p_dest)) bad_hold++;
      tready = 1'($urandom_range(0, 1));
      if (tvalid === 1'b1 && tready) begin
        if ($isunknown(tdest) || int'(tdest) >= 4) bad_dest++;
        else begin
          if (tdata[31:0] !== 32'(cnt[tdest])) bad_seq++;
          cnt[tdest]++;
        end
        n++;
      end
      p_stall = (tvalid === 1'b1) && !tready;
      p_data = tdata; p_dest = tdest;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rnd_timeout: got done=%b after %0d cycles want 1", done, cyc); end
    n_checks++; if (n != 4096) begin n_fail++; $display("FAIL rnd_beats: got %0d want 4096", n); end
    n_checks++; if (total_sent !== 32'd4096 || sent_sum() !== 32'd4096) begin n_fail++; $display("FAIL rnd_totals: got %0d/%0d want 4096/4096", total_sent, sent_sum()); end
    n_checks++; if (bad_dest != 0) begin n_fail++; $display("FAIL rnd_dest: got %0d bad dests want 0", bad_dest); end
    n_checks++; if (bad_seq != 0) begin n_fail++; $display("FAIL rnd_seq: got %0d seq gaps want 0", bad_seq); end
    n_checks++; if (bad_hold != 0) begin n_fail++; $display("FAIL rnd_hold: got %0d unstable stalls want 0", bad_hold); end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_zero_load;
    test_zero_packets;
    test_backpressure;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
